pipe_mem_io_stage: RTL
======================

Name: pipe_mem_io_stage

Overview:
- MEM stage of the pipelined CPU with IO: holds the EX/MEM pipeline register, the word-addressed data RAM and the memory-mapped IO registers, plus the MEM/WB pipeline register.
- Takes the EXE stage results (ALU result, store data, destination register, control).
- Drives the write-back stage and exports M-stage values for forwarding back into EXE.
- The consumer end of the EXE stage's result interface.

Parameters:
- RAM_AW, 5, log2 of data RAM depth in 32-bit words (default 32 words).
- IO_BASE, 32'h0000_0080, base of the 128-byte IO window; compare bits [31:7] only.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ewreg  in  1  EXE: instruction writes the register file.
- em2reg  in  1  EXE: write-back selects memory data.
- ewmem  in  1  EXE: store.
- ealu  in  32  EXE: ALU result or pc+8; the effective address for load/store.
- eb  in  32  EXE: store data (forwarded rt value).
- ern  in  5  EXE: destination register.
- in_port0  in  32  external switches, asynchronous to clock.
- in_port1  in  32  external keys, asynchronous to clock.
- mwreg, mm2reg  out  1 each  M-stage control, for hazard/forwarding.
- malu  out  32  M-stage ALU result, forwarded to EXE.
- mrn  out  5  M-stage destination register.
- wwreg, wm2reg  out  1 each  WB control.
- wmo  out  32  WB memory/IO read data.
- walu  out  32  WB ALU result.
- wrn  out  5  WB destination register.
- out_port0, out_port1, out_port2  out  32 each  IO output registers (LED/seven-segment).

Behaviour:
- Reset (resetn low, asynchronous): clear all pipeline regs, out_port0..2, and both sync flops.
  - All outputs read 0.
  - RAM contents are not reset.
  - Reset asserted mid-store: the store is lost, no partial write.
- EX/MEM register: at each edge, mwreg/mm2reg/mwmem/malu/mb/mrn <= ewreg/em2reg/ewmem/ealu/eb/ern.
  - No stall or enable input; a bubble arrives as all-zero controls from EXE.
- Address decode (M cycle, combinational on malu):
  - io_sel = (malu[31:7] == IO_BASE[31:7]).
  - RAM word index = malu[RAM_AW+1:2]. Bits [1:0] ignored, so a misaligned address accesses the enclosing word.
  - RAM aliases across all non-IO addresses.
- RAM:
  - Asynchronous read.
  - Write at the rising edge ending the M cycle when mwmem and !io_sel.
  - A load in the cycle after a store to the same word returns the new data.
- IO registers, selected by malu[4:2] when io_sel:
  - 0: out_port0 (read/write).
  - 1: out_port1 (read/write).
  - 2: out_port2 (read/write).
  - 4: in_port0, synchronized (read-only; writes ignored).
  - 5: in_port1, synchronized (read-only; writes ignored).
  - Other selects: read 32'h0, writes ignored.
  - out_port writes take effect at the edge ending the M cycle and are visible on the pins the next cycle.
- Input sync: two-flop synchronizer per in_port, free-running. A pin change is readable at the latest 2 edges later.
- M-stage read data mmo = io_sel ? io_rdata : ram[index]. mmo is computed every cycle regardless of mm2reg.
- MEM/WB register: at each edge, wwreg/wm2reg/wmo/walu/wrn <= mwreg/mm2reg/mmo/malu/mrn.
- Latency:
  - EXE inputs to M outputs: 1 cycle.
  - EXE inputs to WB outputs: 2 cycles.
  - Store visible to a following load: 1 cycle.
- Forwarding and load-use stalls are handled by the hazard unit; this block only exports mrn/mwreg/mm2reg/malu.
- Simultaneous reset and store: reset wins; no RAM write.

Decomposition:
- Shared package/header:
  - IO select codes (IO_OUT0=0, IO_OUT1=1, IO_OUT2=2, IO_IN0=4, IO_IN1=5).
  - IO_BASE default.
  - RAM_AW default.
- One natural sub-module: pipe_io_regs. It contains the three out_port registers, the two-flop synchronizers and the read mux, with inputs clock/resetn/we/sel/wdata.
- The RAM and both pipeline registers stay in the top.

Test Plan:
- Reset: drive resetn low mid-run with ewmem=1, ealu=0x4, eb=0xDEAD -> all outputs 0 immediately; after release, a load of 0x4 does not return 0xDEAD.
- Store then load: store eb=0x12345678 at ealu=0x8, next cycle load ealu=0x8 em2reg=1 ewreg=1 ern=3 -> two edges after the load, wmo=0x12345678, wrn=3, wm2reg=1.
- Aliasing/misalignment: store 0xA5A5A5A5 at 0x10 -> loads of 0x13 and of 0x10+(4<<RAM_AW)=0x90-region non-IO equivalent 0x110 return 0xA5A5A5A5.
- IO out: store 0x000000FF to 0x84 -> out_port1=0xFF one cycle after the M cycle; out_port0/2 unchanged. A store to 0x8C (sel 3) changes nothing, and its read returns 0.
- IO in: set in_port0=0x5, wait 2 cycles, load 0x90 -> wmo=0x5; a store to 0x90 leaves the read value at 0x5.
- Pipeline/forwarding: back-to-back ALU ops ern=5 ealu=0x11 then ern=6 ealu=0x22 -> mrn/malu show 5/0x11 then 6/0x22; walu/wrn follow one cycle later with wm2reg=0.

Source files
------------

// File: rtl/pipe_mem_io_stage_pkg.sv
// Shared definitions for the MEM stage: IO select codes, default geometry, pipeline register layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the pipeline has no stall input.
package pipe_mem_io_stage_pkg;

  // Default data RAM depth (log2 of 32-bit words) and IO window base.
  localparam int          RAM_AW_DEF  = 5;
  localparam logic [31:0] IO_BASE_DEF = 32'h0000_0080;

  // IO register selects, taken from address bits [4:2] inside the IO window.
  localparam logic [2:0] IO_OUT0 = 3'd0;
  localparam logic [2:0] IO_OUT1 = 3'd1;
  localparam logic [2:0] IO_OUT2 = 3'd2;
  localparam logic [2:0] IO_IN0  = 3'd4;
  localparam logic [2:0] IO_IN1  = 3'd5;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } em_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } mw_t;

  // The IO window is 128 bytes, so only bits [31:7] take part in the match.
  function automatic logic io_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:7] == base[31:7]);
  endfunction

endpackage

// File: rtl/pipe_mem_io_stage_io_regs.sv
// Memory-mapped IO: three output registers, two synchronised input ports, read mux.
// Latency: writes land at the edge ending the M cycle; input pins readable within 2 edges; reads combinational.
// Backpressure: none; accepts a write every cycle.
module pipe_io_regs
  import pipe_mem_io_stage_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] rdata,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  logic [31:0] r_out0;
  logic [31:0] r_out1;
  logic [31:0] r_out2;
  logic [31:0] r_in0_meta;
  logic [31:0] r_in0_sync;
  logic [31:0] r_in1_meta;
  logic [31:0] r_in1_sync;

  // Output registers: only the three writable selects accept store data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out0 <= 32'h0;
      r_out1 <= 32'h0;
      r_out2 <= 32'h0;
    end else if (we) begin
      case (sel)
        IO_OUT0: r_out0 <= wdata;
        IO_OUT1: r_out1 <= wdata;
        IO_OUT2: r_out2 <= wdata;
        default: ;
      endcase
    end
  end

  // Free-running two-flop synchronisers; the pins are asynchronous to clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_in0_meta <= 32'h0;
      r_in0_sync <= 32'h0;
      r_in1_meta <= 32'h0;
      r_in1_sync <= 32'h0;
    end else begin
      r_in0_meta <= in_port0;
      r_in0_sync <= r_in0_meta;
      r_in1_meta <= in_port1;
      r_in1_sync <= r_in1_meta;
    end
  end

  // Read mux; unmapped selects read as zero.
  always_comb begin
    rdata = 32'h0;
    case (sel)
      IO_OUT0: rdata = r_out0;
      IO_OUT1: rdata = r_out1;
      IO_OUT2: rdata = r_out2;
      IO_IN0:  rdata = r_in0_sync;
      IO_IN1:  rdata = r_in1_sync;
      default: rdata = 32'h0;
    endcase
  end

  assign out_port0 = r_out0;
  assign out_port1 = r_out1;
  assign out_port2 = r_out2;

endmodule

// File: rtl/pipe_mem_io_stage.sv
// MEM stage: EX/MEM register, word-addressed data RAM, memory-mapped IO, MEM/WB register.
// Latency: EXE inputs to M outputs 1 cycle, to WB outputs 2 cycles; store visible to the next load.
// Backpressure: none; a new instruction is accepted every cycle, bubbles arrive as zero controls.
module pipe_mem_io_stage
  import pipe_mem_io_stage_pkg::*;
#(
  parameter int          RAM_AW  = RAM_AW_DEF,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  em_t         r_em;
  mw_t         r_mw;
  logic [31:0] r_ram [2**RAM_AW];

  logic              w_io_sel;
  logic [RAM_AW-1:0] w_idx;
  logic              w_ram_we;
  logic              w_io_we;
  logic [31:0]       w_io_rdata;
  logic [31:0]       w_mmo;

  // EX/MEM register: unconditional capture, no enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_em <= '0;
    end else begin
      r_em.wreg  <= ewreg;
      r_em.m2reg <= em2reg;
      r_em.wmem  <= ewmem;
      r_em.alu   <= ealu;
      r_em.b     <= eb;
      r_em.rn    <= ern;
    end
  end

  // Decode: everything outside the IO window aliases onto the RAM; byte offset is dropped.
  assign w_io_sel = io_hit(r_em.alu, IO_BASE);
  assign w_idx    = r_em.alu[RAM_AW+1:2];
  assign w_ram_we = r_em.wmem & ~w_io_sel;
  assign w_io_we  = r_em.wmem &  w_io_sel;

  // Data RAM write port; contents survive reset, and reset clears wmem so no partial store.
  always_ff @(posedge clock) begin
    if (w_ram_we) begin
      r_ram[w_idx] <= r_em.b;
    end
  end

  pipe_io_regs u_io_regs (
    .clock     (clock),
    .resetn    (resetn),
    .we        (w_io_we),
    .sel       (r_em.alu[4:2]),
    .wdata     (r_em.b),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .rdata     (w_io_rdata),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2)
  );

  // Read data is formed every cycle whether or not the instruction is a load.
  assign w_mmo = w_io_sel ? w_io_rdata : r_ram[w_idx];

  // MEM/WB register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mw <= '0;
    end else begin
      r_mw.wreg  <= r_em.wreg;
      r_mw.m2reg <= r_em.m2reg;
      r_mw.mo    <= w_mmo;
      r_mw.alu   <= r_em.alu;
      r_mw.rn    <= r_em.rn;
    end
  end

  assign mwreg  = r_em.wreg;
  assign mm2reg = r_em.m2reg;
  assign malu   = r_em.alu;
  assign mrn    = r_em.rn;
  assign wwreg  = r_mw.wreg;
  assign wm2reg = r_mw.m2reg;
  assign wmo    = r_mw.mo;
  assign walu   = r_mw.alu;
  assign wrn    = r_mw.rn;

endmodule
